glyph_fetch_arbiter: RTL and testbench



---
 rtl/glyph_fetch_arbiter_pkg.sv | 27 ++
 rtl/glyph_fetch_arbiter_if.sv | 37 +++
 rtl/glyph_fetch_arbiter_rr.sv | 32 +++
 rtl/glyph_fetch_arbiter.sv | 151 +++++++++++++++
 tb/tb_glyph_fetch_arbiter.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glyph_fetch_arbiter_pkg.sv
// rtl/glyph_fetch_arbiter_pkg.sv - shared constants, FSM state encoding and helpers (package glyph_pkg)
//
// Purpose : single source of widths and encodings for the glyph fetch arbiter,
//           its bus interface and its round-robin sub-module.
// Ports   : none (package).
package glyph_pkg;

  localparam int NUM_REQ = 4;
  localparam int DIGIT_W = 4;
  localparam int ROW_W   = 6;
  localparam int GLYPH_W = 64;
  localparam int ID_W    = 2;

  // Highest digit code that has a glyph in the ROM; codes above it are errors.
  localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic digit_in_range(input logic [DIGIT_W-1:0] digit);
    return digit <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/glyph_fetch_arbiter_if.sv
// rtl/glyph_fetch_arbiter_if.sv - request/ROM/response bundle of the glyph fetch arbiter
//
// Purpose : groups every non-clock, non-reset signal of the arbiter.
// Signals : req/req_digit/req_row   requester side (packed, requester i at slice i)
//           grant                   one-hot, one-cycle acknowledge
//           mux_digit/mux_index_Y   address to the external glyph ROM mux
//           mux_spo                 combinational ROM mux data
//           rsp_valid/rsp_ready     response handshake
//           rsp_id/rsp_data/rsp_err response payload
// Modports: master = requesters + ROM + consumer side, slave = the arbiter.
interface glyph_fetch_arbiter_if;
  import glyph_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*DIGIT_W-1:0] req_digit;
  logic [NUM_REQ*ROW_W-1:0]   req_row;
  logic [NUM_REQ-1:0]         grant;
  logic [DIGIT_W-1:0]         mux_digit;
  logic [ROW_W-1:0]           mux_index_Y;
  logic [GLYPH_W-1:0]         mux_spo;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [ID_W-1:0]            rsp_id;
  logic [GLYPH_W-1:0]         rsp_data;
  logic                       rsp_err;

  modport master (
    output req, req_digit, req_row, mux_spo, rsp_ready,
    input  grant, mux_digit, mux_index_Y, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req, req_digit, req_row, mux_spo, rsp_ready,
    output grant, mux_digit, mux_index_Y, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/glyph_fetch_arbiter_rr.sv
// rtl/glyph_fetch_arbiter_rr.sv - four-way round-robin selector (module rr_arbiter4)
//
// Purpose : picks the first set request bit searching upward from pointer,
//           wrapping modulo 4. Purely combinational.
// Ports   : req     in  4  request vector
//           pointer in  2  index where the search starts
//           grant   out 4  one-hot selection, zero when req is zero
module rr_arbiter4
  import glyph_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    pointer,
  output logic [NUM_REQ-1:0] grant
);

  logic [ID_W-1:0] idx;

  // Walk from the farthest offset down to offset 0 so the closest set bit
  // to the pointer is the one left standing.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = pointer + ID_W'(i);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/glyph_fetch_arbiter.sv
// rtl/glyph_fetch_arbiter.sv - round-robin glyph ROM fetch arbiter with registered response
//
// Purpose : arbitrates four glyph-row fetch requesters onto one external ROM
//           mux, registers the returned row and holds it until consumed.
// Ports   : Clk    in  1  system clock
//           Reset  in  1  asynchronous, active-high reset
//           bus    slave modport of glyph_fetch_arbiter_if (request, ROM mux
//                  address/data and response handshake)
// Config  : GLYPH_LAST_ROW_CACHE_EN adds a one-entry {digit,row} cache of the
//           last ROM read; a hit skips the ADDR cycle.
module glyph_fetch_arbiter
  import glyph_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  glyph_fetch_arbiter_if.slave bus
);

  state_t             state;
  logic [NUM_REQ-1:0] grant_q;
  logic [DIGIT_W-1:0] mux_digit_q;
  logic [ROW_W-1:0]   mux_row_q;
  logic               rsp_valid_q;
  logic               rsp_err_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [GLYPH_W-1:0] rsp_data_q;
  logic [ID_W-1:0]    rr_ptr;

  logic [NUM_REQ-1:0] sel_grant;
  logic [ID_W-1:0]    sel_id;
  logic [DIGIT_W-1:0] sel_digit;
  logic [ROW_W-1:0]   sel_row;

  logic               cache_hit;
  logic [GLYPH_W-1:0] cache_rd_data;

  rr_arbiter4 u_rr (
    .req     (bus.req),
    .pointer (rr_ptr),
    .grant   (sel_grant)
  );

  // Unpack the winning requester's id, digit and row.
  always_comb begin
    sel_id    = '0;
    sel_digit = '0;
    sel_row   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_grant[i]) begin
        sel_id    = ID_W'(i);
        sel_digit = bus.req_digit[i*DIGIT_W +: DIGIT_W];
        sel_row   = bus.req_row[i*ROW_W +: ROW_W];
      end
    end
  end

`ifdef GLYPH_LAST_ROW_CACHE_EN
  logic               cache_valid;
  logic [DIGIT_W-1:0] cache_digit;
  logic [ROW_W-1:0]   cache_row;
  logic [GLYPH_W-1:0] cache_data;

  // Refilled on every ROM read, i.e. at the closing edge of ADDR.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cache_valid <= 1'b0;
      cache_digit <= '0;
      cache_row   <= '0;
      cache_data  <= '0;
    end else if (state == ADDR) begin
      cache_valid <= 1'b1;
      cache_digit <= mux_digit_q;
      cache_row   <= mux_row_q;
      cache_data  <= bus.mux_spo;
    end
  end

  assign cache_hit     = cache_valid && (cache_digit == sel_digit) && (cache_row == sel_row);
  assign cache_rd_data = cache_data;
`else
  assign cache_hit     = 1'b0;
  assign cache_rd_data = '0;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      grant_q     <= '0;
      mux_digit_q <= '0;
      mux_row_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rr_ptr      <= '0;
    end else begin
      grant_q <= '0;
      case (state)
        IDLE: begin
          if (|sel_grant) begin
            grant_q  <= sel_grant;
            rsp_id_q <= sel_id;
            rr_ptr   <= sel_id + ID_W'(1);
            if (!digit_in_range(sel_digit)) begin
              // No glyph exists for this code: answer at once without
              // touching the ROM address.
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else if (cache_hit) begin
              rsp_err_q   <= 1'b0;
              rsp_data_q  <= cache_rd_data;
              rsp_valid_q <= 1'b1;
              state       <= RESP;
            end else begin
              rsp_err_q   <= 1'b0;
              mux_digit_q <= sel_digit;
              mux_row_q   <= sel_row;
              state       <= ADDR;
            end
          end
        end
        ADDR: begin
          rsp_data_q  <= bus.mux_spo;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant_q;
  assign bus.mux_digit   = mux_digit_q;
  assign bus.mux_index_Y = mux_row_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_glyph_fetch_arbiter.sv
// tb/tb_glyph_fetch_arbiter.sv - directed self-checking bench for glyph_fetch_arbiter
`timescale 1ns/1ps
module tb_glyph_fetch_arbiter;
  import glyph_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] rom_xor = 64'h0;
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;

  always #5 clk = ~clk;

  glyph_fetch_arbiter_if bus ();

  function automatic logic [63:0] rom_model(input logic [3:0] d, input logic [5:0] r);
    if (d == 4'd3 && r == 6'd10) return 64'hA5;
    return {16'hBEEF, 36'h0, 2'b00, r, d};
  endfunction

  assign bus.mux_spo = rom_model(bus.mux_digit, bus.mux_index_Y) ^ rom_xor;

  glyph_fetch_arbiter dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_src(input int id, input logic [3:0] d, input logic [5:0] r);
    bus.req_digit[id*4 +: 4] = d;
    bus.req_row[id*6 +: 6]   = r;
  endtask

  task automatic apply_reset;
    bus.req       = '0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Complete the outstanding response; caller has already dropped req.
  task automatic drain(input string tag);
    int t = 0;
    bus.rsp_ready = 1'b1;
    while (bus.rsp_valid !== 1'b1 && t < 6) begin
      tick;
      t++;
    end
    n_vec++;
    if (bus.rsp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_drain: rsp_valid=%b required 1 within 6 cycles", tag, bus.rsp_valid);
    end
    tick;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    bus.req       = '0;
    bus.req_digit = '0;
    bus.req_row   = '0;
    bus.rsp_ready = 1'b0;
    reset = 1'b1;
    tick;
    n_vec++; if (bus.grant !== 4'b0)     begin n_err++; $display("FAIL reset_grant: got %b required 0000", bus.grant); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b required 0", bus.rsp_valid); end
    n_vec++; if (bus.rsp_err !== 1'b0)   begin n_err++; $display("FAIL reset_rsp_err: got %b required 0", bus.rsp_err); end
    n_vec++; if (bus.rsp_id !== 2'd0)    begin n_err++; $display("FAIL reset_rsp_id: got %0d required 0", bus.rsp_id); end
    n_vec++; if (bus.rsp_data !== 64'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h required 0", bus.rsp_data); end
    n_vec++; if (bus.mux_digit !== 4'h0) begin n_err++; $display("FAIL reset_mux_digit: got %h required 0", bus.mux_digit); end
    n_vec++; if (bus.mux_index_Y !== 6'h0) begin n_err++; $display("FAIL reset_mux_index_Y: got %h required 0", bus.mux_index_Y); end
    reset = 1'b0;
    // rsp_ready with nothing pending must not create a response
    bus.rsp_ready = 1'b1;
    tick;
    tick;
    n_vec++; if (bus.rsp_valid !== 1'b0 || bus.grant !== 4'b0) begin
      n_err++; $display("FAIL idle_ready: rsp_valid=%b grant=%b required 0 and 0000", bus.rsp_valid, bus.grant);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_single;
    set_src(1, 4'd3, 6'd10);
    bus.req = 4'b0010;
    tick;
    n_vec++; if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL single_grant: got %b required 0010", bus.grant); end
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_early: got %b required 0", bus.rsp_valid); end
    n_vec++; if (bus.mux_digit !== 4'd3 || bus.mux_index_Y !== 6'd10) begin
      n_err++; $display("FAIL single_mux_addr: got %0d/%0d required 3/10", bus.mux_digit, bus.mux_index_Y);
    end
    bus.req = 4'b0000;
    tick;
    n_vec++; if (bus.grant !== 4'b0) begin n_err++; $display("FAIL single_grant_pulse: got %b required 0000", bus.grant); end
    n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_data !== 64'hA5 || bus.rsp_err !== 1'b0) begin
      n_err++; $display("FAIL single_rsp: valid=%b id=%0d data=%h err=%b required 1/1/a5/0",
                        bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
    end
    bus.rsp_ready = 1'b1;
    tick;
    n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_release: rsp_valid=%b required 0", bus.rsp_valid); end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_contention;
    int last_cyc = 0;
    apply_reset;
    for (int i = 0; i < 4; i++) set_src(i, 4'(i + 1), 6'(4 * i + 2));
    bus.req       = 4'b1111;
    bus.rsp_ready = 1'b1;
    for (int n = 0; n < 5; n++) begin
      int t = 0;
      logic [3:0] exp_g;
      exp_g = 4'b0001 << (n % 4);
      while (bus.grant === 4'b0 && t < 8) begin
        tick;
        t++;
      end
      n_vec++; if (bus.grant !== exp_g) begin
        n_err++; $display("FAIL contention_order[%0d]: got %b required %b", n, bus.grant, exp_g);
      end
      if (n > 0) begin
        n_vec++; if (cyc - last_cyc != 3) begin
          n_err++; $display("FAIL contention_spacing[%0d]: got %0d cycles required 3", n, cyc - last_cyc);
        end
      end
      last_cyc = cyc;
      if (n == 4) bus.req = 4'b0000;
      tick;
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(n % 4) ||
                   bus.rsp_data !== rom_model(4'(n % 4 + 1), 6'(4 * (n % 4) + 2))) begin
        n_err++; $display("FAIL contention_rsp[%0d]: valid=%b id=%0d data=%h required 1/%0d/%h", n,
                          bus.rsp_valid, bus.rsp_id, bus.rsp_data, n % 4,
                          rom_model(4'(n % 4 + 1), 6'(4 * (n % 4) + 2)));
      end
    end
    tick;
    bus.rsp_ready = 1'b0;
  endtask

  // Pointer is at 1 after contention; requesters 2 and 3 both ask, 2 wins.
  task automatic test_backpressure;
    logic [63:0] exp_d;
    exp_d = rom_model(4'd7, 6'd33);
    set_src(2, 4'd7, 6'd33);
    set_src(3, 4'd2, 6'd5);
    bus.rsp_ready = 1'b0;
    bus.req = 4'b1100;
    tick;
    n_vec++; if (bus.grant !== 4'b0100) begin n_err++; $display("FAIL bp_grant: got %b required 0100", bus.grant); end
    bus.req = 4'b1000;
    tick;
    n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d) begin
      n_err++; $display("FAIL bp_first: valid=%b data=%h required 1/%h", bus.rsp_valid, bus.rsp_data, exp_d);
    end
    for (int s = 0; s < 5; s++) begin
      tick;
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.grant !== 4'b0 || bus.rsp_id !== 2'd2) begin
        n_err++; $display("FAIL bp_stall[%0d]: valid=%b data=%h grant=%b id=%0d required 1/%h/0000/2",
                          s, bus.rsp_valid, bus.rsp_data, bus.grant, bus.rsp_id, exp_d);
      end
    end
    bus.rsp_ready = 1'b1;
    tick;
    n_vec++; if (bus.rsp_valid !== 1'b0 || bus.grant !== 4'b0) begin
      n_err++; $display("FAIL bp_release: valid=%b grant=%b required 0/0000", bus.rsp_valid, bus.grant);
    end
    bus.rsp_ready = 1'b0;
    tick;
    n_vec++; if (bus.grant !== 4'b1000) begin n_err++; $display("FAIL bp_next_grant: got %b required 1000", bus.grant); end
    bus.req = 4'b0000;
    drain("bp");
  endtask

  task automatic test_invalid_digit;
    int          tv_id [3]  = '{2, 3, 1};
    logic [3:0]  tv_dig[3]  = '{4'd12, 4'd8, 4'd9};
    logic [5:0]  tv_row[3]  = '{6'd5, 6'd63, 6'd0};
    logic        tv_err[3]  = '{1'b1, 1'b0, 1'b1};
    for (int v = 0; v < 3; v++) begin
      int t = 0;
      logic [63:0] exp_d;
      exp_d = tv_err[v] ? 64'h0 : rom_model(tv_dig[v], tv_row[v]);
      set_src(tv_id[v], tv_dig[v], tv_row[v]);
      bus.req = 4'b0001 << tv_id[v];
      while (bus.grant === 4'b0 && t < 6) begin
        tick;
        t++;
      end
      n_vec++; if (bus.grant !== (4'b0001 << tv_id[v])) begin
        n_err++; $display("FAIL digit_grant[%0d]: got %b required %b", v, bus.grant, 4'b0001 << tv_id[v]);
      end
      bus.req = 4'b0000;
      t = 0;
      while (bus.rsp_valid !== 1'b1 && t < 4) begin
        tick;
        t++;
      end
      n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(tv_id[v]) ||
                   bus.rsp_err !== tv_err[v] || bus.rsp_data !== exp_d) begin
        n_err++; $display("FAIL digit_rsp[%0d]: valid=%b id=%0d err=%b data=%h required 1/%0d/%b/%h", v,
                          bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, tv_id[v], tv_err[v], exp_d);
      end
      drain("digit");
    end
  endtask

  // Requester 0 is granted first, so a pointer that survived reset would sit
  // at 1; with 0011 pending afterwards only a cleared pointer picks 0.
  task automatic test_reset_in_addr;
    set_src(0, 4'd4, 6'd20);
    set_src(1, 4'd6, 6'd21);
    bus.req = 4'b0001;
    tick;
    n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL raddr_grant: got %b required 0001", bus.grant); end
    bus.req = 4'b0000;
    reset = 1'b1;
    #1;
    n_vec++; if (bus.grant !== 4'b0 || bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_id !== 2'd0 ||
                 bus.rsp_data !== 64'h0 || bus.mux_digit !== 4'h0 || bus.mux_index_Y !== 6'h0) begin
      n_err++; $display("FAIL raddr_async: grant=%b valid=%b err=%b id=%0d data=%h digit=%h row=%h required all 0",
                        bus.grant, bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.rsp_data, bus.mux_digit, bus.mux_index_Y);
    end
    tick;
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    tick;
    tick;
    n_vec++; if (bus.rsp_valid !== 1'b0 || bus.grant !== 4'b0) begin
      n_err++; $display("FAIL raddr_aborted: valid=%b grant=%b required 0/0000", bus.rsp_valid, bus.grant);
    end
    bus.rsp_ready = 1'b0;
    bus.req = 4'b0011;
    tick;
    n_vec++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL raddr_pointer: got %b required 0001", bus.grant); end
    bus.req = 4'b0000;
    drain("raddr");
  endtask

`ifdef GLYPH_LAST_ROW_CACHE_EN
  task automatic test_cache;
    logic [63:0] exp_d;
    exp_d = rom_model(4'd5, 6'd7);
    set_src(1, 4'd5, 6'd7);
    bus.req = 4'b0010;
    tick;
    n_vec++; if (bus.grant !== 4'b0010 || bus.rsp_valid !== 1'b0) begin
      n_err++; $display("FAIL cache_miss: grant=%b valid=%b required 0010/0", bus.grant, bus.rsp_valid);
    end
    bus.req = 4'b0000;
    tick;
    n_vec++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d) begin
      n_err++; $display("FAIL cache_fill: valid=%b data=%h required 1/%h", bus.rsp_valid, bus.rsp_data, exp_d);
    end
    drain("cache_fill");
    // a hit must return the stored row, not whatever the ROM now shows
    rom_xor = 64'hFFFF_0000_FFFF_0000;
    bus.req = 4'b0010;
    tick;
    n_vec++; if (bus.grant !== 4'b0010 || bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp_d || bus.rsp_err !== 1'b0) begin
      n_err++; $display("FAIL cache_hit: grant=%b valid=%b data=%h err=%b required 0010/1/%h/0",
                        bus.grant, bus.rsp_valid, bus.rsp_data, bus.rsp_err, exp_d);
    end
    bus.req = 4'b0000;
    drain("cache_hit");
    rom_xor = 64'h0;
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_invalid_digit;
    test_reset_in_addr;
`ifdef GLYPH_LAST_ROW_CACHE_EN
    test_cache;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
